rc_receiver_nch: RTL and testbench

//  Parametrised N-channel RC receiver front end: measures the high time of each servo-style PWM input
//  in us_clk ticks, converts it to an unsigned command value, and drives failsafe values on signal loss.
//  It replaces the fixed four-channel receiver between the RC inputs and the angle_controller.

---
 rtl/rc_receiver_nch_pkg.sv | 18 +
 rtl/rc_receiver_nch_if.sv | 31 +++
 rtl/rc_receiver_nch_capture.sv | 133 +++++++++++++
 rtl/rc_receiver_nch.sv | 90 +++++++++
 tb/tb_rc_receiver_nch.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc_receiver_nch_pkg.sv
// Shared definitions for the N-channel RC receiver: default timing constants,
// the command value width and the per-channel capture state encoding.
package rc_receiver_nch_pkg;

    localparam int REC_VAL_BIT_WIDTH = 8;

    localparam int DEF_MIN_US       = 1000;
    localparam int DEF_MIN_VALID_US = 800;
    localparam int DEF_MAX_VALID_US = 2200;
    localparam int DEF_TIMEOUT_US   = 50000;

    typedef enum logic [1:0] {
        CH_WAIT_LOW = 2'd0,
        CH_ARMED    = 2'd1,
        CH_HIGH     = 2'd2
    } chState_t;

endpackage

// File: rtl/rc_receiver_nch_if.sv
// Bus bundle between the RC inputs, the receiver and the downstream controller.
interface rc_receiver_nch_if
    import rc_receiver_nch_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int VAL_WIDTH = REC_VAL_BIT_WIDTH
);

    logic [N_CH-1:0]           pwm_in;
    logic [N_CH*VAL_WIDTH-1:0] ch_val;
    logic                      valid_strobe;
    logic                      failsafe;
    logic [N_CH-1:0]           glitch_flags;

    modport master (
        output pwm_in,
        input  ch_val,
        input  valid_strobe,
        input  failsafe,
        input  glitch_flags
    );

    modport slave (
        input  pwm_in,
        output ch_val,
        output valid_strobe,
        output failsafe,
        output glitch_flags
    );

endinterface

// File: rtl/rc_receiver_nch_capture.sv
// One PWM capture channel: synchroniser, pulse-measuring FSM, saturating width
// and timeout counters, and the width-to-command-value mapping.
module pwm_capture_channel
    import rc_receiver_nch_pkg::*;
#(
    parameter int VAL_WIDTH    = REC_VAL_BIT_WIDTH,
    parameter int CNT_WIDTH    = 16,
    parameter int MIN_US       = DEF_MIN_US,
    parameter int SHIFT        = 2,
    parameter int MIN_VALID_US = DEF_MIN_VALID_US,
    parameter int MAX_VALID_US = DEF_MAX_VALID_US,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
    parameter logic [VAL_WIDTH-1:0] FAILSAFE_VAL = '0
) (
    input  logic                 us_clk,
    input  logic                 resetn,
    input  logic                 i_pwm,
    output logic [VAL_WIDTH-1:0] o_value,
    output logic                 o_pulseDoneValid,
    output logic                 o_glitch,
    output logic                 o_lost
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] C_MIN_US    = CNT_WIDTH'(MIN_US);
    localparam logic [CNT_WIDTH-1:0] C_MIN_VALID = CNT_WIDTH'(MIN_VALID_US);
    localparam logic [CNT_WIDTH-1:0] C_MAX_VALID = CNT_WIDTH'(MAX_VALID_US);
    localparam logic [CNT_WIDTH-1:0] C_TIMEOUT   = CNT_WIDTH'(TIMEOUT_US);
    localparam logic [CNT_WIDTH-1:0] C_VAL_MAX   = CNT_WIDTH'((2 ** VAL_WIDTH) - 1);

    logic [1:0]           r_sync;
    chState_t             r_state;
    logic [CNT_WIDTH-1:0] r_width;
    logic [CNT_WIDTH-1:0] r_timeout;
    logic [VAL_WIDTH-1:0] r_value;
    logic                 r_done;
    logic                 r_glitch;

    logic                 w_pwmSync;
    logic                 w_fall;
    logic                 w_inRange;
    logic                 w_evalValid;
    logic                 w_evalGlitch;
    logic [CNT_WIDTH-1:0] w_offset;
    logic [CNT_WIDTH-1:0] w_shifted;
    logic [VAL_WIDTH-1:0] w_value;

    assign w_pwmSync = r_sync[1];

    // Two-flop synchroniser; resets high so a pulse already in progress at reset
    // release is seen as high and the FSM waits for a genuine low first.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_pwm};
        end
    end

    // Falling-edge width evaluation, value mapping and loss detection.
    always_comb begin
        w_fall       = (r_state == CH_HIGH) && !w_pwmSync;
        w_inRange    = (r_width >= C_MIN_VALID) && (r_width <= C_MAX_VALID);
        w_evalValid  = w_fall && w_inRange;
        w_evalGlitch = w_fall && !w_inRange;
        w_offset     = r_width - C_MIN_US;
        w_shifted    = w_offset >> SHIFT;
        w_value      = '0;
        if (r_width < C_MIN_US) begin
            w_value = '0;
        end else if (w_shifted > C_VAL_MAX) begin
            w_value = '1;
        end else begin
            w_value = w_shifted[VAL_WIDTH-1:0];
        end
        o_lost = (r_timeout >= C_TIMEOUT) && !w_evalValid;
    end

    // Capture FSM with width/timeout counters and registered per-channel results.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= CH_WAIT_LOW;
            r_width   <= '0;
            r_timeout <= '0;
            r_value   <= FAILSAFE_VAL;
            r_done    <= 1'b0;
            r_glitch  <= 1'b0;
        end else begin
            case (r_state)
                CH_WAIT_LOW: begin
                    if (!w_pwmSync) begin
                        r_state <= CH_ARMED;
                    end
                end
                CH_ARMED: begin
                    if (w_pwmSync) begin
                        r_state <= CH_HIGH;
                        r_width <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                CH_HIGH: begin
                    if (!w_pwmSync) begin
                        r_state <= CH_ARMED;
                    end else if (r_width != CNT_MAX) begin
                        r_width <= r_width + 1'b1;
                    end
                end
                default: begin
                    r_state <= CH_WAIT_LOW;
                end
            endcase

            r_done <= w_evalValid;
            if (w_evalValid) begin
                r_value <= w_value;
            end
            if (w_evalGlitch) begin
                r_glitch <= 1'b1;
            end

            if (w_evalValid) begin
                r_timeout <= '0;
            end else if (r_timeout != CNT_MAX) begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

    assign o_value          = r_value;
    assign o_pulseDoneValid = r_done;
    assign o_glitch         = r_glitch;

endmodule

// File: rtl/rc_receiver_nch.sv
// N-channel RC receiver front end: per-channel capture, frame-complete strobe,
// failsafe management and output selection.
module rc_receiver_nch
    import rc_receiver_nch_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int VAL_WIDTH    = REC_VAL_BIT_WIDTH,
    parameter int CNT_WIDTH    = 16,
    parameter int MIN_US       = DEF_MIN_US,
    parameter int SHIFT        = 2,
    parameter int MIN_VALID_US = DEF_MIN_VALID_US,
    parameter int MAX_VALID_US = DEF_MAX_VALID_US,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
    parameter logic [N_CH*VAL_WIDTH-1:0] FAILSAFE_VALS = {8'h80, 8'h80, 8'h80, 8'h00}
) (
    input  logic              us_clk,
    input  logic              resetn,
    rc_receiver_nch_if.slave  bus
);

    logic [N_CH*VAL_WIDTH-1:0] w_heldVals;
    logic [N_CH-1:0]           w_done;
    logic [N_CH-1:0]           w_glitch;
    logic [N_CH-1:0]           w_lost;
    logic                      w_anyLost;
    logic                      w_fire;
    logic [N_CH-1:0]           w_seenNext;

    logic                      r_failsafe;
    logic [N_CH-1:0]           r_seen;
    logic [N_CH-1:0]           r_fresh;
    logic                      r_strobe;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_capture_channel #(
            .VAL_WIDTH    (VAL_WIDTH),
            .CNT_WIDTH    (CNT_WIDTH),
            .MIN_US       (MIN_US),
            .SHIFT        (SHIFT),
            .MIN_VALID_US (MIN_VALID_US),
            .MAX_VALID_US (MAX_VALID_US),
            .TIMEOUT_US   (TIMEOUT_US),
            .FAILSAFE_VAL (FAILSAFE_VALS[k*VAL_WIDTH +: VAL_WIDTH])
        ) u_capture (
            .us_clk           (us_clk),
            .resetn           (resetn),
            .i_pwm            (bus.pwm_in[k]),
            .o_value          (w_heldVals[k*VAL_WIDTH +: VAL_WIDTH]),
            .o_pulseDoneValid (w_done[k]),
            .o_glitch         (w_glitch[k]),
            .o_lost           (w_lost[k])
        );
    end

    assign w_anyLost  = |w_lost;
    assign w_fire     = (&r_fresh) && !r_failsafe;
    assign w_seenNext = r_seen | w_done;

    // Failsafe entry clears recovery and frame tracking; recovery needs one valid
    // pulse per channel since entry. Fresh bits set while the strobe fires carry over.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_failsafe <= 1'b1;
            r_seen     <= '0;
            r_fresh    <= '0;
            r_strobe   <= 1'b0;
        end else if (!r_failsafe && w_anyLost) begin
            r_failsafe <= 1'b1;
            r_seen     <= '0;
            r_fresh    <= '0;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe <= w_fire;
            r_fresh  <= w_fire ? w_done : (r_fresh | w_done);
            if (r_failsafe) begin
                r_seen <= w_seenNext;
                if ((&w_seenNext) && !w_anyLost) begin
                    r_failsafe <= 1'b0;
                    r_seen     <= '0;
                end
            end
        end
    end

    assign bus.ch_val       = r_failsafe ? FAILSAFE_VALS : w_heldVals;
    assign bus.valid_strobe = r_strobe;
    assign bus.failsafe     = r_failsafe;
    assign bus.glitch_flags = w_glitch;

endmodule

// File: tb/tb_rc_receiver_nch.sv
// Directed testbench for rc_receiver_nch: pulse mapping, glitch rejection,
// timeout failsafe, strobe framing and reset behaviour.
module tb_rc_receiver_nch;

    localparam logic [31:0] FS_VALS = 32'h8080_8000;

    logic us_clk;
    logic resetn;
    int   checks;
    int   failures;
    int   strobeCount;
    int   cycleCount;

    rc_receiver_nch_if #(.N_CH(4), .VAL_WIDTH(8)) bus ();

    rc_receiver_nch dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Free-running 1 MHz-equivalent tick clock.
    initial begin
        us_clk = 1'b0;
        forever #5 us_clk = ~us_clk;
    end

    // Cycle counter used to place events relative to a captured edge.
    always @(posedge us_clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Strobe monitor sampled away from the active edge.
    always @(negedge us_clk) begin
        if (resetn === 1'b1 && bus.valid_strobe === 1'b1) begin
            strobeCount = strobeCount + 1;
        end
    end

    // Drives the channels in mask high for exactly width cycles, returns at the falling edge.
    task automatic applyStimulus(input logic [3:0] mask, input int width);
        @(negedge us_clk);
        bus.pwm_in = bus.pwm_in | mask;
        repeat (width) @(negedge us_clk);
        bus.pwm_in = bus.pwm_in & ~mask;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        bus.pwm_in = 4'b0000;
        repeat (5) @(negedge us_clk);
        checks++;
        if (bus.ch_val !== FS_VALS || bus.failsafe !== 1'b1 || bus.valid_strobe !== 1'b0 || bus.glitch_flags !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_state: ch_val=%h fs=%b strobe=%b glitch=%b, expected %h 1 0 0000",
                     bus.ch_val, bus.failsafe, bus.valid_strobe, bus.glitch_flags, FS_VALS);
        end
        resetn = 1'b1;
        repeat (10) @(negedge us_clk);
    endtask

    task automatic test_basic_frame();
        int base;
        base = strobeCount;
        applyStimulus(4'b1111, 1500);
        checks++;
        if (bus.failsafe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame_fs_before: failsafe=%b expected 1", bus.failsafe);
        end
        repeat (6) @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_fs_after: failsafe=%b expected 0", bus.failsafe);
        end
        checks++;
        if (bus.ch_val !== {4{8'd125}}) begin
            failures++;
            $display("[TB] FAIL frame_values: ch_val=%h expected %h", bus.ch_val, {4{8'd125}});
        end
        repeat (10) @(negedge us_clk);
        checks++;
        if (strobeCount - base !== 1) begin
            failures++;
            $display("[TB] FAIL frame_strobe: strobes=%0d expected 1", strobeCount - base);
        end
    endtask

    task automatic test_ch1_mapping();
        applyStimulus(4'b0010, 900);
        repeat (5) @(negedge us_clk);
        checks++;
        if (bus.ch_val[15:8] !== 8'd0) begin
            failures++;
            $display("[TB] FAIL ch1_900us: value=%0d expected 0", bus.ch_val[15:8]);
        end
        repeat (50) @(negedge us_clk);
        applyStimulus(4'b0010, 2100);
        repeat (5) @(negedge us_clk);
        checks++;
        if (bus.ch_val[15:8] !== 8'd255) begin
            failures++;
            $display("[TB] FAIL ch1_2100us: value=%0d expected 255", bus.ch_val[15:8]);
        end
        checks++;
        if (bus.glitch_flags !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL glitch_clear: glitch=%b expected 0000", bus.glitch_flags);
        end
        repeat (50) @(negedge us_clk);
        applyStimulus(4'b0010, 700);
        repeat (5) @(negedge us_clk);
        checks++;
        if (bus.ch_val[15:8] !== 8'd255 || bus.glitch_flags !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL ch1_700us: value=%0d glitch=%b expected 255 0010", bus.ch_val[15:8], bus.glitch_flags);
        end
        repeat (50) @(negedge us_clk);
        applyStimulus(4'b0010, 2300);
        repeat (5) @(negedge us_clk);
        checks++;
        if (bus.ch_val[15:8] !== 8'd255 || bus.glitch_flags !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL ch1_2300us: value=%0d glitch=%b expected 255 0010", bus.ch_val[15:8], bus.glitch_flags);
        end
        repeat (50) @(negedge us_clk);
    endtask

    task automatic test_staggered();
        int base;
        base = strobeCount;
        applyStimulus(4'b0100, 2000);
        repeat (20) @(negedge us_clk);
        applyStimulus(4'b1000, 1200);
        repeat (5) @(negedge us_clk);
        checks++;
        if (bus.ch_val[31:24] !== 8'd50) begin
            failures++;
            $display("[TB] FAIL stag_ch3_first: value=%0d expected 50", bus.ch_val[31:24]);
        end
        repeat (20) @(negedge us_clk);
        applyStimulus(4'b1000, 1600);
        repeat (20) @(negedge us_clk);
        checks++;
        if (bus.ch_val[31:24] !== 8'd150 || strobeCount !== base) begin
            failures++;
            $display("[TB] FAIL stag_ch3_second: value=%0d strobes=%0d expected 150 0", bus.ch_val[31:24], strobeCount - base);
        end
        applyStimulus(4'b0001, 1800);
        repeat (2) @(posedge us_clk);
        #1;
        checks++;
        if (bus.ch_val[7:0] !== 8'd125) begin
            failures++;
            $display("[TB] FAIL stag_latency_early: value=%0d expected 125", bus.ch_val[7:0]);
        end
        @(posedge us_clk);
        #1;
        checks++;
        if (bus.ch_val[7:0] !== 8'd200) begin
            failures++;
            $display("[TB] FAIL stag_latency_third_edge: value=%0d expected 200", bus.ch_val[7:0]);
        end
        repeat (10) @(negedge us_clk);
        checks++;
        if (strobeCount - base !== 1) begin
            failures++;
            $display("[TB] FAIL stag_strobe: strobes=%0d expected 1", strobeCount - base);
        end
        checks++;
        if (bus.ch_val !== {8'd150, 8'd250, 8'd255, 8'd200}) begin
            failures++;
            $display("[TB] FAIL stag_values: ch_val=%h expected %h", bus.ch_val, {8'd150, 8'd250, 8'd255, 8'd200});
        end
    endtask

    task automatic test_timeout_failsafe();
        int t0;
        int base;
        applyStimulus(4'b1111, 1500);
        repeat (3) @(posedge us_clk);
        @(negedge us_clk);
        t0 = cycleCount;
        repeat (20) @(negedge us_clk);
        base = strobeCount;
        for (int i = 1; i <= 3; i++) begin
            while (cycleCount < t0 + i * 15000) @(negedge us_clk);
            applyStimulus(4'b1011, 1500);
        end
        while (cycleCount < t0 + 50000) @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_not_yet: failsafe=%b expected 0", bus.failsafe);
        end
        @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_asserted: failsafe=%b expected 1", bus.failsafe);
        end
        checks++;
        if (bus.ch_val !== FS_VALS) begin
            failures++;
            $display("[TB] FAIL timeout_values: ch_val=%h expected %h", bus.ch_val, FS_VALS);
        end
        repeat (20) @(negedge us_clk);
        applyStimulus(4'b1011, 1500);
        repeat (10) @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b1 || bus.ch_val !== FS_VALS) begin
            failures++;
            $display("[TB] FAIL recover_partial: failsafe=%b ch_val=%h expected 1 %h", bus.failsafe, bus.ch_val, FS_VALS);
        end
        checks++;
        if (strobeCount !== base) begin
            failures++;
            $display("[TB] FAIL timeout_no_strobe: strobes=%0d expected 0", strobeCount - base);
        end
        applyStimulus(4'b0100, 1500);
        repeat (6) @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b0 || bus.ch_val !== {4{8'd125}}) begin
            failures++;
            $display("[TB] FAIL recover_full: failsafe=%b ch_val=%h expected 0 %h", bus.failsafe, bus.ch_val, {4{8'd125}});
        end
        repeat (20) @(negedge us_clk);
    endtask

    task automatic test_reset_release_high();
        @(negedge us_clk);
        resetn     = 1'b0;
        bus.pwm_in = 4'b0001;
        repeat (5) @(negedge us_clk);
        resetn = 1'b1;
        repeat (600) @(negedge us_clk);
        bus.pwm_in = 4'b0000;
        repeat (20) @(negedge us_clk);
        checks++;
        if (bus.glitch_flags !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rel_high_no_glitch: glitch=%b expected 0000", bus.glitch_flags);
        end
        applyStimulus(4'b1110, 1500);
        repeat (10) @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rel_high_ignored: failsafe=%b expected 1", bus.failsafe);
        end
        applyStimulus(4'b0001, 1200);
        repeat (6) @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b0 || bus.ch_val[7:0] !== 8'd50) begin
            failures++;
            $display("[TB] FAIL rel_high_next: failsafe=%b ch0=%0d expected 0 50", bus.failsafe, bus.ch_val[7:0]);
        end
    endtask

    task automatic test_reset_mid_pulse();
        applyStimulus(4'b1000, 500);
        repeat (5) @(negedge us_clk);
        checks++;
        if (bus.glitch_flags !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL mid_pre_glitch: glitch=%b expected 1000", bus.glitch_flags);
        end
        @(negedge us_clk);
        bus.pwm_in = 4'b0001;
        repeat (500) @(negedge us_clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.ch_val !== FS_VALS || bus.failsafe !== 1'b1 || bus.valid_strobe !== 1'b0 || bus.glitch_flags !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: ch_val=%h fs=%b strobe=%b glitch=%b expected %h 1 0 0000",
                     bus.ch_val, bus.failsafe, bus.valid_strobe, bus.glitch_flags, FS_VALS);
        end
        repeat (1000) @(negedge us_clk);
        bus.pwm_in = 4'b0000;
        repeat (5) @(negedge us_clk);
        resetn = 1'b1;
        repeat (30) @(negedge us_clk);
        checks++;
        if (bus.failsafe !== 1'b1 || bus.glitch_flags !== 4'b0000 || bus.ch_val !== FS_VALS) begin
            failures++;
            $display("[TB] FAIL mid_partial_dropped: fs=%b glitch=%b ch_val=%h expected 1 0000 %h",
                     bus.failsafe, bus.glitch_flags, bus.ch_val, FS_VALS);
        end
    endtask

    // Sequential scenario driver.
    initial begin
        checks      = 0;
        failures    = 0;
        strobeCount = 0;
        cycleCount  = 0;
        resetn      = 1'b0;
        bus.pwm_in  = 4'b0000;
        test_reset();
        test_basic_frame();
        test_ch1_mapping();
        test_staggered();
        test_timeout_failsafe();
        test_reset_release_high();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
